// File: rtl/ti_share_recombiner.sv
// Serial XOR recombiner for threshold-implementation shares: collects NSHARES beats, emits the
// unmasked word. Optional build macro TI_RECOMB_ZEROIZE_EN clears unmasked data after use.
module ti_share_recombiner #(
    parameter int unsigned NSHARES = 3,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CW      = $clog2(NSHARES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_share,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             err,
    output logic [CW-1:0]    share_idx
);

    localparam logic [CW-1:0] LastIdx = CW'(NSHARES - 1);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] m_data_q;
    logic             m_valid_q;
    logic             err_q;
    logic [CW-1:0]    share_idx_q;
    logic             at_last;

    assign at_last = (share_idx_q == LastIdx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            acc_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            share_idx_q <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StCollect: begin
`ifdef TI_RECOMB_ZEROIZE_EN
                    if (share_idx_q == '0) acc_q <= '0;
`endif
                    if (s_valid) begin
                        if (at_last && s_last) begin
                            m_data_q    <= acc_q ^ s_share;
                            m_valid_q   <= 1'b1;
                            acc_q       <= '0;
                            share_idx_q <= '0;
                            state_q     <= StHold;
                        end else if (!at_last && !s_last) begin
                            acc_q       <= acc_q ^ s_share;
                            share_idx_q <= share_idx_q + CW'(1);
                        end else begin
                            // Malformed group: drop the share and restart collection.
                            err_q       <= 1'b1;
                            acc_q       <= '0;
                            share_idx_q <= '0;
                        end
                    end
                end
                StHold: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= StCollect;
`ifdef TI_RECOMB_ZEROIZE_EN
                        m_data_q  <= '0;
`endif
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    always_comb begin
        s_ready   = (state_q == StCollect);
        m_valid   = m_valid_q;
        err       = err_q;
        share_idx = share_idx_q;
`ifdef TI_RECOMB_ZEROIZE_EN
        m_data    = m_valid_q ? m_data_q : '0;
`else
        m_data    = m_data_q;
`endif
    end

endmodule
